// File: rtl/axi4_lite_slave_mem_pkg.sv
// Shared definitions for the AXI4-Lite slave memory: bus widths,
// FSM state encodings and the address range check.
package axi4_lite_Defs;

   localparam int Addr_Width = 32;
   localparam int Data_Width = 32;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_DATA = 2'd2
   } rd_state_t;

   // True when a byte address falls inside a memory of 'words' 32-bit words.
   function automatic logic addr_in_range(input logic [Addr_Width-1:0] addr,
                                          input int unsigned words);
      return 64'(addr) < (64'(words) * 64'd4);
   endfunction

endpackage

// File: rtl/axi4_lite_slave_mem_if.sv
// AXI4-Lite channel bundle (AR, R, AW, W, B) without response codes
// or write strobes. Clock and reset are carried separately.
interface axi4_lite_slave_mem_if;
   import axi4_lite_Defs::*;

   logic [Addr_Width-1:0] ARADDR;
   logic                  ARVALID;
   logic                  ARREADY;
   logic [Data_Width-1:0] RDATA;
   logic                  RVALID;
   logic                  RREADY;
   logic [Addr_Width-1:0] AWADDR;
   logic                  AWVALID;
   logic                  AWREADY;
   logic [Data_Width-1:0] WDATA;
   logic                  WVALID;
   logic                  WREADY;
   logic                  BVALID;
   logic                  BREADY;

   modport master (
      output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WVALID, BREADY,
      input  ARREADY, RDATA, RVALID, AWREADY, WREADY, BVALID
   );

   modport slave (
      input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WVALID, BREADY,
      output ARREADY, RDATA, RVALID, AWREADY, WREADY, BVALID
   );

endinterface

// File: rtl/axi4_lite_slave_mem_array.sv
// Word storage for the AXI4-Lite slave: one synchronous write port,
// one combinational read port, whole array cleared by reset.
module axi4_lite_slave_mem_array
   import axi4_lite_Defs::*;
#(
   parameter int MEM_WORDS = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we,
   input  logic [$clog2(MEM_WORDS)-1:0] widx,
   input  logic [Data_Width-1:0]        wdata,
   input  logic [$clog2(MEM_WORDS)-1:0] ridx,
   output logic [Data_Width-1:0]        rdata
);

   logic [Data_Width-1:0] mem [MEM_WORDS];

   // Clear every word on reset; otherwise commit one word per write strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   assign rdata = mem[ridx];

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave in front of a word-addressed register memory.
// Independent read and write FSMs, one outstanding transaction each.
// Optional macro AXI4_LITE_SLV_WAIT_EN inserts WAIT_CYCLES of extra
// read latency (R_WAIT state); memory is sampled when the wait ends.
module axi4_lite_slave_mem
   import axi4_lite_Defs::*;
#(
   parameter int MEM_WORDS   = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   axi4_lite_slave_mem_if.slave bus
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   // ---------------- write side ----------------
   wr_state_t             wr_state, wr_state_n;
   logic                  aw_cap, aw_cap_n;
   logic                  w_cap, w_cap_n;
   logic [Addr_Width-1:0] awaddr_q, awaddr_n;
   logic [Data_Width-1:0] wdata_q, wdata_n;
   logic                  awready_q, awready_n;
   logic                  wready_q, wready_n;
   logic                  bvalid_q, bvalid_n;
   logic                  aw_hs, w_hs;
   logic                  mem_we;
   logic [Addr_Width-1:0] commit_addr;
   logic [Data_Width-1:0] commit_data;

   assign aw_hs = bus.AWVALID && awready_q;
   assign w_hs  = bus.WVALID && wready_q;

   // Write FSM next state: capture AW/W independently, commit when both held.
   always_comb begin
      wr_state_n  = wr_state;
      aw_cap_n    = aw_cap;
      w_cap_n     = w_cap;
      awaddr_n    = awaddr_q;
      wdata_n     = wdata_q;
      bvalid_n    = bvalid_q;
      mem_we      = 1'b0;
      commit_addr = aw_hs ? bus.AWADDR : awaddr_q;
      commit_data = w_hs ? bus.WDATA : wdata_q;
      case (wr_state)
         W_IDLE: begin
            if (aw_hs) begin
               aw_cap_n = 1'b1;
               awaddr_n = bus.AWADDR;
            end
            if (w_hs) begin
               w_cap_n = 1'b1;
               wdata_n = bus.WDATA;
            end
            if (aw_cap_n && w_cap_n) begin
               // Out-of-range writes still complete on B but never touch memory.
               mem_we     = addr_in_range(commit_addr, MEM_WORDS);
               wr_state_n = W_RESP;
               bvalid_n   = 1'b1;
            end
         end
         W_RESP: begin
            if (bus.BREADY) begin
               wr_state_n = W_IDLE;
               bvalid_n   = 1'b0;
               aw_cap_n   = 1'b0;
               w_cap_n    = 1'b0;
            end
         end
         default: begin
            wr_state_n = W_IDLE;
            bvalid_n   = 1'b0;
            aw_cap_n   = 1'b0;
            w_cap_n    = 1'b0;
         end
      endcase
      awready_n = (wr_state_n == W_IDLE) && !aw_cap_n;
      wready_n  = (wr_state_n == W_IDLE) && !w_cap_n;
   end

   // Write FSM registers, captures and registered READY/BVALID outputs.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_state  <= W_IDLE;
         aw_cap    <= 1'b0;
         w_cap     <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
      end else begin
         wr_state  <= wr_state_n;
         aw_cap    <= aw_cap_n;
         w_cap     <= w_cap_n;
         awaddr_q  <= awaddr_n;
         wdata_q   <= wdata_n;
         awready_q <= awready_n;
         wready_q  <= wready_n;
         bvalid_q  <= bvalid_n;
      end
   end

   // ---------------- read side ----------------
   rd_state_t             rd_state, rd_state_n;
   logic                  arready_q, arready_n;
   logic                  rvalid_q, rvalid_n;
   logic [Data_Width-1:0] rdata_q, rdata_n;
   logic                  ar_hs;
   logic [Addr_Width-1:0] rd_addr;
   logic [Data_Width-1:0] mem_rdata;
   logic [Data_Width-1:0] rd_word;

   assign ar_hs = bus.ARVALID && arready_q;

`ifdef AXI4_LITE_SLV_WAIT_EN
   localparam int                CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   logic [Addr_Width-1:0] araddr_q, araddr_n;
   logic [CNT_W-1:0]      cnt_q, cnt_n;

   assign rd_addr = (rd_state == R_WAIT) ? araddr_q : bus.ARADDR;
`else
   logic [31:0] wait_cfg_unused;

   assign wait_cfg_unused = 32'(WAIT_CYCLES);
   assign rd_addr         = bus.ARADDR;
`endif

   assign rd_word = addr_in_range(rd_addr, MEM_WORDS) ? mem_rdata : '0;

   // Read FSM next state: sample memory at AR handshake (or wait exit), hold until RREADY.
   always_comb begin
      rd_state_n = rd_state;
      rvalid_n   = rvalid_q;
      rdata_n    = rdata_q;
`ifdef AXI4_LITE_SLV_WAIT_EN
      araddr_n   = araddr_q;
      cnt_n      = cnt_q;
`endif
      case (rd_state)
         R_IDLE: begin
            if (ar_hs) begin
`ifdef AXI4_LITE_SLV_WAIT_EN
               if (WAIT_CYCLES > 0) begin
                  rd_state_n = R_WAIT;
                  araddr_n   = bus.ARADDR;
                  cnt_n      = CNT_LOAD;
               end else begin
                  rd_state_n = R_DATA;
                  rdata_n    = rd_word;
                  rvalid_n   = 1'b1;
               end
`else
               rd_state_n = R_DATA;
               rdata_n    = rd_word;
               rvalid_n   = 1'b1;
`endif
            end
         end
`ifdef AXI4_LITE_SLV_WAIT_EN
         R_WAIT: begin
            if (cnt_q == '0) begin
               rd_state_n = R_DATA;
               rdata_n    = rd_word;
               rvalid_n   = 1'b1;
            end else begin
               cnt_n = cnt_q - 1'b1;
            end
         end
`endif
         R_DATA: begin
            if (bus.RREADY) begin
               rd_state_n = R_IDLE;
               rvalid_n   = 1'b0;
            end
         end
         default: begin
            rd_state_n = R_IDLE;
            rvalid_n   = 1'b0;
         end
      endcase
      arready_n = (rd_state_n == R_IDLE);
   end

   // Read FSM registers and registered ARREADY/RVALID/RDATA outputs.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rd_state  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
`ifdef AXI4_LITE_SLV_WAIT_EN
         araddr_q  <= '0;
         cnt_q     <= '0;
`endif
      end else begin
         rd_state  <= rd_state_n;
         arready_q <= arready_n;
         rvalid_q  <= rvalid_n;
         rdata_q   <= rdata_n;
`ifdef AXI4_LITE_SLV_WAIT_EN
         araddr_q  <= araddr_n;
         cnt_q     <= cnt_n;
`endif
      end
   end

   // ---------------- storage ----------------
   axi4_lite_slave_mem_array #(
      .MEM_WORDS (MEM_WORDS)
   ) u_array (
      .clk   (ACLK),
      .rst   (ARESET),
      .we    (mem_we),
      .widx  (commit_addr[IDX_W+1:2]),
      .wdata (commit_data),
      .ridx  (rd_addr[IDX_W+1:2]),
      .rdata (mem_rdata)
   );

   assign bus.AWREADY = awready_q;
   assign bus.WREADY  = wready_q;
   assign bus.BVALID  = bvalid_q;
   assign bus.ARREADY = arready_q;
   assign bus.RVALID  = rvalid_q;
   assign bus.RDATA   = rdata_q;

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Directed bench for axi4_lite_slave_mem with a read-data scoreboard
// and a behavioural word model of the memory.
module tb_axi4_lite_slave_mem;
   import axi4_lite_Defs::*;

`ifdef AXI4_LITE_SLV_WAIT_EN
   localparam int EXP_LAT = 1 + 2;
`else
   localparam int EXP_LAT = 1;
`endif

   logic ACLK   = 1'b0;
   logic ARESET = 1'b1;

   axi4_lite_slave_mem_if bus ();

   axi4_lite_slave_mem #(
      .MEM_WORDS   (64),
      .WAIT_CYCLES (2)
   ) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus)
   );

   always #5 ACLK = ~ACLK;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] model [64];
   logic [31:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      return (a < 32'd256) ? model[a[7:2]] : 32'h0;
   endfunction

   task automatic do_read(input logic [31:0] a, input int hold, input string tag);
      logic [31:0] exp;
      int          lat;
      int          n;
      bus.ARADDR  = a;
      bus.ARVALID = 1'b1;
      exp_q.push_back(model_rd(a));
      n = 0;
      while (bus.ARREADY !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_arready"}, 32'(bus.ARREADY), 32'd1);
      step();
      bus.ARVALID = 1'b0;
      bus.ARADDR  = '0;
      lat = 1;
      while (bus.RVALID !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(EXP_LAT));
      exp = exp_q.pop_front();
      chk({tag, "_rdata"}, bus.RDATA, exp);
      for (int i = 0; i < hold; i++) begin
         step();
         chk({tag, "_hold_rvalid"}, 32'(bus.RVALID), 32'd1);
         chk({tag, "_hold_rdata"}, bus.RDATA, exp);
         chk({tag, "_hold_arready"}, 32'(bus.ARREADY), 32'd0);
      end
      bus.RREADY = 1'b1;
      step();
      bus.RREADY = 1'b0;
      chk({tag, "_rvalid_drop"}, 32'(bus.RVALID), 32'd0);
      chk({tag, "_arready_back"}, 32'(bus.ARREADY), 32'd1);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int aw_dly,
                           input int w_dly, input int bhold, input string tag);
      logic aw_done, w_done, aw_hs, w_hs;
      int   c;
      aw_done = 1'b0;
      w_done  = 1'b0;
      c       = 0;
      while (!(aw_done && w_done) && c < 30) begin
         bus.AWADDR  = a;
         bus.WDATA   = d;
         bus.AWVALID = !aw_done && (c >= aw_dly);
         bus.WVALID  = !w_done && (c >= w_dly);
         aw_hs = bus.AWVALID && bus.AWREADY;
         w_hs  = bus.WVALID && bus.WREADY;
         step();
         c++;
         if (aw_hs) aw_done = 1'b1;
         if (w_hs)  w_done  = 1'b1;
         if (w_done && !aw_done) chk({tag, "_wready_low"}, 32'(bus.WREADY), 32'd0);
         if (aw_done && !w_done) chk({tag, "_awready_low"}, 32'(bus.AWREADY), 32'd0);
      end
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      chk({tag, "_handshakes"}, {30'd0, aw_done, w_done}, 32'd3);
      chk({tag, "_commit_cycle"}, 32'(c), 32'((aw_dly > w_dly ? aw_dly : w_dly) + 1));
      chk({tag, "_bvalid"}, 32'(bus.BVALID), 32'd1);
      chk({tag, "_readys_low"}, {30'd0, bus.AWREADY, bus.WREADY}, 32'd0);
      if (a < 32'd256) model[a[7:2]] = d;
      for (int i = 0; i < bhold; i++) begin
         step();
         chk({tag, "_bvalid_hold"}, 32'(bus.BVALID), 32'd1);
      end
      bus.BREADY = 1'b1;
      step();
      bus.BREADY = 1'b0;
      chk({tag, "_bvalid_drop"}, 32'(bus.BVALID), 32'd0);
      chk({tag, "_readys_back"}, {30'd0, bus.AWREADY, bus.WREADY}, 32'd3);
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_ctrl"}, {27'd0, bus.ARREADY, bus.AWREADY, bus.WREADY, bus.RVALID, bus.BVALID}, 32'd0);
      chk({tag, "_rdata"}, bus.RDATA, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp;
      int          lat;
      for (int i = 0; i < 64; i++) model[i] = 32'h0;
      bus.ARADDR  = '0;
      bus.ARVALID = 1'b0;
      bus.RREADY  = 1'b0;
      bus.AWADDR  = '0;
      bus.AWVALID = 1'b0;
      bus.WDATA   = '0;
      bus.WVALID  = 1'b0;
      bus.BREADY  = 1'b0;

      // Reset then idle
      #12;
      chk_outs_zero("reset_outs");
      step();
      ARESET = 1'b0;
      step();
      chk("release_readys", {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'd7);
      do_read(32'h10, 0, "idle_rd");

      // Write then read, with B back-pressure
      do_write(32'h08, 32'hDEADBEEF, 0, 0, 3, "wr08");
      do_read(32'h08, 0, "rd08");

      // Split write: W first, AW four cycles later
      do_write(32'h04, 32'h12345678, 4, 0, 0, "split");
      do_read(32'h06, 0, "rd06");

      // Out of range read with R back-pressure, out of range write
      do_read(32'h400, 5, "rd_oor");
      do_write(32'h400, 32'hCAFEF00D, 0, 0, 0, "wr_oor");
      do_read(32'h0, 0, "rd00_alias");

      // Collision: write commit and AR handshake on the same edge
      bus.AWADDR  = 32'h20;
      bus.WDATA   = 32'hA5A5A5A5;
      bus.AWVALID = 1'b1;
      bus.WVALID  = 1'b1;
      bus.ARADDR  = 32'h20;
      bus.ARVALID = 1'b1;
`ifdef AXI4_LITE_SLV_WAIT_EN
      exp_q.push_back(32'hA5A5A5A5);
`else
      exp_q.push_back(model_rd(32'h20));
`endif
      step();
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      bus.ARVALID = 1'b0;
      model[8]    = 32'hA5A5A5A5;
      chk("coll_bvalid", 32'(bus.BVALID), 32'd1);
      lat = 1;
      while (bus.RVALID !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      chk("coll_latency", 32'(lat), 32'(EXP_LAT));
      exp = exp_q.pop_front();
      chk("coll_rdata", bus.RDATA, exp);
      bus.RREADY = 1'b1;
      bus.BREADY = 1'b1;
      step();
      bus.RREADY = 1'b0;
      bus.BREADY = 1'b0;
      chk("coll_done", {30'd0, bus.RVALID, bus.BVALID}, 32'd0);
      do_read(32'h20, 0, "coll_rd_new");

      // Reset mid-write: AW accepted, W still pending
      bus.AWADDR  = 32'h0C;
      bus.AWVALID = 1'b1;
      step();
      bus.AWVALID = 1'b0;
      chk("midwr_aw_taken", {30'd0, bus.AWREADY, bus.WREADY}, 32'd1);
      #2;
      ARESET = 1'b1;
      #1;
      chk_outs_zero("midwr_reset_outs");
      step();
      ARESET = 1'b0;
      for (int i = 0; i < 64; i++) model[i] = 32'h0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("midwr_no_bvalid", 32'(bus.BVALID), 32'd0);
      end
      chk("midwr_readys", {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'd7);
      do_read(32'h0C, 0, "midwr_rd0c");
      do_read(32'h08, 0, "midwr_rd08_cleared");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
